// File: rtl/cond_status_unit_if.sv
// ID/EXE status bus between the pipeline and cond_status_unit.
// master drives instruction/status info; slave (the unit) returns ready/exec.
interface cond_status_unit_if;
   logic       id_valid;
   logic [3:0] id_cond;
   logic       id_set_flags;
   logic       id_ready;
   logic       id_exec;
   logic       exe_wr_en;
   logic [3:0] exe_status;

   modport master (
      output id_valid, id_cond, id_set_flags, exe_wr_en, exe_status,
      input  id_ready, id_exec
   );

   modport slave (
      input  id_valid, id_cond, id_set_flags, exe_wr_en, exe_status,
      output id_ready, id_exec
   );
endinterface

// File: rtl/cond_status_unit.sv
// NZCV status register, ARM condition evaluation and flag-writer hazard tracking.
// Optional FLAG_FWD_EN: same-cycle bypass of the EXE status to the ID condition check.
module cond_status_unit #(
   parameter  int unsigned PEND_MAX = 3,
   localparam int unsigned CNT_W    = $clog2(PEND_MAX + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   cond_status_unit_if.slave    bus,
   output logic [3:0]           status_q,
   output logic                 alu_cin,
   output logic [CNT_W-1:0]     pend_cnt,
   output logic                 pend_err
);

   logic [3:0]       status_d;
   logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
   logic             pend_err_q, pend_err_d;
   logic [3:0]       flags_c;
   logic             fwd_hit_c;
   logic             needs_flags_c, hazard_c, full_c;
   logic             id_ready_c, id_exec_c, issue_wr_c;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0:    cond_pass = z;
         4'h1:    cond_pass = ~z;
         4'h2:    cond_pass = c;
         4'h3:    cond_pass = ~c;
         4'h4:    cond_pass = n;
         4'h5:    cond_pass = ~n;
         4'h6:    cond_pass = v;
         4'h7:    cond_pass = ~v;
         4'h8:    cond_pass = c & ~z;
         4'h9:    cond_pass = ~c | z;
         4'hA:    cond_pass = (n == v);
         4'hB:    cond_pass = (n != v);
         4'hC:    cond_pass = ~z & (n == v);
         4'hD:    cond_pass = z | (n != v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   // Issue qualification, flag source selection and next-state for counter/status.
   always_comb begin
      fwd_hit_c  = 1'b0;
`ifdef FLAG_FWD_EN
      fwd_hit_c  = (pend_cnt_q == CNT_W'(1)) && bus.exe_wr_en && !flush;
`endif
      flags_c       = fwd_hit_c ? bus.exe_status : status_q;
      needs_flags_c = (bus.id_cond != 4'hE) && (bus.id_cond != 4'hF);
      hazard_c      = needs_flags_c && (pend_cnt_q != '0) && !fwd_hit_c;
      full_c        = bus.id_set_flags && (pend_cnt_q == CNT_W'(PEND_MAX));
      id_ready_c    = ~hazard_c & ~full_c;
      id_exec_c     = bus.id_valid & id_ready_c & cond_pass(bus.id_cond, flags_c);
      issue_wr_c    = id_exec_c & bus.id_set_flags;

      status_d   = bus.exe_wr_en ? bus.exe_status : status_q;
      pend_err_d = pend_err_q | (bus.exe_wr_en && (pend_cnt_q == '0));
      pend_cnt_d = pend_cnt_q;
      if (flush) begin
         pend_cnt_d = '0;
      end else begin
         case ({issue_wr_c, bus.exe_wr_en})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
            2'b01:   if (pend_cnt_q != '0) pend_cnt_d = pend_cnt_q - CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         status_q   <= 4'b0000;
         pend_cnt_q <= '0;
         pend_err_q <= 1'b0;
      end else begin
         status_q   <= status_d;
         pend_cnt_q <= pend_cnt_d;
         pend_err_q <= pend_err_d;
      end
   end

   // Carry-in uses committed C only; ADC/SBC in EXE never see a bypassed value.
   assign alu_cin      = status_q[1];
   assign pend_cnt     = pend_cnt_q;
   assign pend_err     = pend_err_q;
   assign bus.id_ready = id_ready_c;
   assign bus.id_exec  = id_exec_c;

endmodule

// File: tb/tb_cond_status_unit.sv
// Scoreboard bench for cond_status_unit: driver queues expectations, negedge monitor checks.
module tb_cond_status_unit;
   localparam int unsigned CNT_W = 2;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic [3:0]       status_q;
   logic             alu_cin;
   logic [CNT_W-1:0] pend_cnt;
   logic             pend_err;

   cond_status_unit_if bus ();

   cond_status_unit #(.PEND_MAX(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .bus      (bus),
      .status_q (status_q),
      .alu_cin  (alu_cin),
      .pend_cnt (pend_cnt),
      .pend_err (pend_err)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic       rdy;
      logic       exec;
      logic [3:0] st;
      logic [1:0] pend;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   cyc_cnt = 0;
   int   checks  = 0;
   int   errors  = 0;

   // Pass masks per condition; bit i is the result for NZCV == i.
   logic [15:0] cond_mask [16] = '{
      16'hF0F0, 16'h0F0F, 16'hCCCC, 16'h3333,
      16'hFF00, 16'h00FF, 16'hAAAA, 16'h5555,
      16'h0C0C, 16'hF3F3, 16'hAA55, 16'h55AA,
      16'h0A05, 16'hF5FA, 16'hFFFF, 16'h0000
   };

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic chk(input string nm, input string fld, input int got, input int want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s.%s got %0h want %0h (cycle %0d)", nm, fld, got, want, cyc_cnt);
      end
   endtask

   // Monitor: pops every expectation due this cycle and compares all visible outputs.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
         exp_t e;
         e = q.pop_front();
         chk(e.name, "id_ready", int'(bus.id_ready), int'(e.rdy));
         chk(e.name, "id_exec",  int'(bus.id_exec),  int'(e.exec));
         chk(e.name, "status_q", int'(status_q),     int'(e.st));
         chk(e.name, "alu_cin",  int'(alu_cin),      int'(e.st[1]));
         chk(e.name, "pend_cnt", int'(pend_cnt),     int'(e.pend));
         chk(e.name, "pend_err", int'(pend_err),     int'(e.err));
      end
   end

   task automatic step(input string nm, input logic v, input logic [3:0] cond,
                       input logic sf, input logic we, input logic [3:0] st_in,
                       input logic fl, input bit do_chk, input logic e_rdy,
                       input logic e_exec, input logic [3:0] e_st,
                       input logic [1:0] e_pend, input logic e_err);
      exp_t e;
      bus.id_valid     = v;
      bus.id_cond      = cond;
      bus.id_set_flags = sf;
      bus.exe_wr_en    = we;
      bus.exe_status   = st_in;
      flush            = fl;
      if (do_chk) begin
         e.cyc  = cyc_cnt;
         e.name = nm;
         e.rdy  = e_rdy;
         e.exec = e_exec;
         e.st   = e_st;
         e.pend = e_pend;
         e.err  = e_err;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step("rst", 0, 4'hE, 0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 2'd0, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n            = 1'b0;
      flush            = 1'b0;
      bus.id_valid     = 1'b0;
      bus.id_cond      = 4'hE;
      bus.id_set_flags = 1'b0;
      bus.exe_wr_en    = 1'b0;
      bus.exe_status   = 4'h0;
      @(posedge clk);
      #1;
      do_reset();

      // Condition table sweep over all 16 NZCV values.
      for (int v = 0; v < 16; v++) begin
         step("load", 0, 4'hE, 0, 1, 4'(v), 0, 0, 0, 0, 4'h0, 2'd0, 0);
         for (int c = 0; c < 16; c++) begin
            logic [15:0] m;
            m = cond_mask[c];
            step($sformatf("cond_f%0h_c%0h", v, c), 1, 4'(c), 0, 0, 4'h0, 0,
                 1, 1, m[v], 4'(v), 2'd0, 1);
         end
      end

      // Asynchronous reset mid-operation with a writer in flight and pend_err set.
      step("t1_load", 0, 4'hE, 0, 1, 4'hF, 0, 0, 0, 0, 4'h0, 2'd0, 0);
      step("t1_iss", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'hF, 2'd0, 1);
      #2 rst_n = 1'b0;
      step("t1_rst", 0, 4'hE, 0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 2'd0, 0);
      rst_n = 1'b1;

      // Hazard on a pending flag writer.
      step("t3_iss", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd0, 0);
      step("t3_stall", 1, 4'h0, 0, 0, 4'h0, 0, 1, 0, 0, 4'h0, 2'd1, 0);
`ifdef FLAG_FWD_EN
      step("t3_wr", 1, 4'h0, 0, 1, 4'h4, 0, 1, 1, 1, 4'h0, 2'd1, 0);
`else
      step("t3_wr", 1, 4'h0, 0, 1, 4'h4, 0, 1, 0, 0, 4'h0, 2'd1, 0);
`endif
      step("t3_after", 1, 4'h0, 0, 0, 4'h0, 0, 1, 1, 1, 4'h4, 2'd0, 0);

      // Full in-flight counter.
      do_reset();
      step("t4_i0", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd0, 0);
      step("t4_i1", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd1, 0);
      step("t4_i2", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd2, 0);
      step("t4_full", 1, 4'hE, 1, 0, 4'h0, 0, 1, 0, 0, 4'h0, 2'd3, 0);
      step("t4_nos", 1, 4'hE, 0, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd3, 0);
      step("t4_wr", 0, 4'hE, 0, 1, 4'h0, 0, 1, 1, 0, 4'h0, 2'd3, 0);
      step("t4_both", 1, 4'hE, 1, 1, 4'h0, 0, 1, 1, 1, 4'h0, 2'd2, 0);
      step("t4_keep", 0, 4'hE, 0, 0, 4'h0, 0, 1, 1, 0, 4'h0, 2'd2, 0);

      // Flush kills in-flight writers but the EXE status still commits.
      do_reset();
      step("t5_i0", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd0, 0);
      step("t5_i1", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h0, 2'd1, 0);
      step("t5_flush", 0, 4'h0, 0, 1, 4'h9, 1, 1, 0, 0, 4'h0, 2'd2, 0);
      step("t5_eq", 1, 4'h0, 0, 0, 4'h0, 0, 1, 1, 0, 4'h9, 2'd0, 0);

      // Unexpected write sets a sticky error.
      do_reset();
      step("t6_wr", 0, 4'hE, 0, 1, 4'h3, 0, 1, 1, 0, 4'h0, 2'd0, 0);
      step("t6_err", 0, 4'hE, 0, 0, 4'h0, 0, 1, 1, 0, 4'h3, 2'd0, 1);
      step("t6_iss", 1, 4'hE, 1, 0, 4'h0, 0, 1, 1, 1, 4'h3, 2'd0, 1);
      step("t6_wb", 0, 4'hE, 0, 1, 4'h5, 0, 1, 1, 0, 4'h3, 2'd1, 1);
      step("t6_stick", 0, 4'hE, 0, 0, 4'h0, 0, 1, 1, 0, 4'h5, 2'd0, 1);
      do_reset();

      @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d want 0 entries left", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
